// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage controller: state encoding and default depth.
package fft_pkg;

  // Default block delay of the controlled shift register (power of two, >= 2).
  localparam int DEFAULT_DEPTH = 16;

  // Frame phases: fill the delay line, combine with the buffer head, then flush it.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    BFLY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fft_stage_ctrl.sv
// FFT stage controller: sequences a radix-2 delay-feedback stage through
// FILL (load DEPTH blocks), BFLY (combine DEPTH blocks with the buffer head)
// and DRAIN (flush DEPTH buffered differences).
// Optional feature: define FFT_CTRL_STALL_CNT_EN to add a 16-bit saturating
// stall_cnt output counting cycles where din_valid=1 but din_ready=0.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sr_shift_en,
  output logic             bfly_en,
  output logic             sel_diff,
  output logic [CNT_W-1:0] tw_idx,
  output logic             dout_valid,
  output logic             frame_done,
  output logic             busy
`ifdef FFT_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             cnt_last;
  logic             is_drain;

  assign cnt_last = (cnt_reg == CNT_LAST);
  assign is_drain = (state_reg == DRAIN);

  // Idle means "at the very start of a frame": nothing buffered yet.
  assign busy = !((state_reg == FILL) && (cnt_reg == '0));

  // Strobes and phase transition, all derived from state, cnt and din_valid.
  // sr_shift_en doubles as the "advance the phase counter" qualifier.
  always_comb begin
    din_ready   = 1'b0;
    sr_shift_en = 1'b0;
    bfly_en     = 1'b0;
    sel_diff    = 1'b0;
    tw_idx      = '0;
    state_next  = state_reg;
    case (state_reg)
      FILL: begin
        din_ready   = 1'b1;
        sr_shift_en = din_valid;
        if (din_valid && cnt_last) begin
          state_next = BFLY;
        end
      end
      BFLY: begin
        din_ready   = 1'b1;
        sr_shift_en = din_valid;
        bfly_en     = din_valid;
        tw_idx      = cnt_reg;
        if (din_valid && cnt_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Input is blocked; the delay line keeps moving to flush differences.
        sr_shift_en = 1'b1;
        sel_diff    = 1'b1;
        if (cnt_last) begin
          state_next = FILL;
        end
      end
      default: begin
        // Unused encoding: fall back to the start of a frame.
        state_next = FILL;
      end
    endcase
  end

  // Phase state, phase counter and the registered output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= FILL;
      cnt_reg    <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
`ifdef FFT_CTRL_STALL_CNT_EN
      stall_cnt  <= 16'd0;
`endif
    end else begin
      state_reg  <= state_next;
      dout_valid <= bfly_en | is_drain;
      frame_done <= is_drain & cnt_last;
      // DEPTH is a power of two, so the counter wraps to 0 exactly at the
      // phase boundary without an explicit clear.
      if (sr_shift_en) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
`ifdef FFT_CTRL_STALL_CNT_EN
      if (din_valid && !din_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl. Two instances (DEPTH=16 and DEPTH=2)
// share one stimulus stream; a frame-position model checks every cycle, and a
// few directed scenarios pin hand-computed cycle numbers.
// Honours FFT_CTRL_STALL_CNT_EN when the design is built with it.
module tb_fft_stage_ctrl;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;

  always #5 clk = ~clk;

  // DEPTH=16 instance
  logic       a_ready, a_shift, a_bfly, a_sel, a_dv, a_fd, a_busy;
  logic [3:0] a_tw;
  // DEPTH=2 instance
  logic       b_ready, b_shift, b_bfly, b_sel, b_dv, b_fd, b_busy;
  logic [0:0] b_tw;
`ifdef FFT_CTRL_STALL_CNT_EN
  logic [15:0] a_stall, b_stall;
`endif

  fft_stage_ctrl #(.DEPTH(16)) u_d16 (
    .clk(clk), .rst(rst), .din_valid(din_valid),
    .din_ready(a_ready), .sr_shift_en(a_shift), .bfly_en(a_bfly),
    .sel_diff(a_sel), .tw_idx(a_tw), .dout_valid(a_dv),
    .frame_done(a_fd), .busy(a_busy)
`ifdef FFT_CTRL_STALL_CNT_EN
    , .stall_cnt(a_stall)
`endif
  );

  fft_stage_ctrl #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .din_valid(din_valid),
    .din_ready(b_ready), .sr_shift_en(b_shift), .bfly_en(b_bfly),
    .sel_diff(b_sel), .tw_idx(b_tw), .dout_valid(b_dv),
    .frame_done(b_fd), .busy(b_busy)
`ifdef FFT_CTRL_STALL_CNT_EN
    , .stall_cnt(b_stall)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is 3*D slots: slots 0..2D-1 are consumed by accepted blocks
  // (first D fill, next D butterfly), slots 2D..3D-1 are drain cycles.
  int depth_of [2] = '{16, 2};
  int pos      [2];
  bit dv_exp   [2];
  bit fd_exp   [2];
  int stall_exp[2];
  bit model_ok = 1'b0;

  task automatic check_inst(input int i, input logic rdy, input logic sh, input logic bf,
                            input logic sd, input logic [31:0] tw, input logic dv,
                            input logic fd, input logic bz, input logic [31:0] st);
    int  d   = depth_of[i];
    int  p   = pos[i];
    bit  bfl = (p >= d) && (p < 2*d);
    bit  drn = (p >= 2*d);
    bit  ebf = bfl && din_valid;
    string tag = $sformatf("d%0d", d);
    check({tag, " din_ready"},   32'(rdy), 32'(!drn));
    check({tag, " sr_shift_en"}, 32'(sh),  32'(drn ? 1'b1 : din_valid));
    check({tag, " bfly_en"},     32'(bf),  32'(ebf));
    check({tag, " sel_diff"},    32'(sd),  32'(drn));
    check({tag, " tw_idx"},      tw,       bfl ? 32'(p - d) : 32'd0);
    check({tag, " busy"},        32'(bz),  32'(p != 0));
    check({tag, " dout_valid"},  32'(dv),  32'(dv_exp[i]));
    check({tag, " frame_done"},  32'(fd),  32'(fd_exp[i]));
`ifdef FFT_CTRL_STALL_CNT_EN
    check({tag, " stall_cnt"},   st,       32'(stall_exp[i]));
`endif
    if (rst) begin
      pos[i] = 0; dv_exp[i] = 1'b0; fd_exp[i] = 1'b0; stall_exp[i] = 0;
    end else begin
      dv_exp[i] = ebf || drn;
      fd_exp[i] = (p == 3*d - 1);
      if (drn && din_valid && stall_exp[i] < 65535) stall_exp[i]++;
      if (drn || din_valid) pos[i] = (p + 1) % (3*d);
    end
  endtask

  // Compare process: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    logic [31:0] sa, sb;
    sa = 32'd0; sb = 32'd0;
`ifdef FFT_CTRL_STALL_CNT_EN
    sa = 32'(a_stall); sb = 32'(b_stall);
`endif
    if (!model_ok) begin
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          pos[i] = 0; dv_exp[i] = 1'b0; fd_exp[i] = 1'b0; stall_exp[i] = 0;
        end
        model_ok = 1'b1;
      end
    end else begin
      check_inst(0, a_ready, a_shift, a_bfly, a_sel, 32'(a_tw), a_dv, a_fd, a_busy, sa);
      check_inst(1, b_ready, b_shift, b_bfly, b_sel, 32'(b_tw), b_dv, b_fd, b_busy, sb);
    end
  end

  // One cycle of stimulus; returns at the falling edge of that cycle.
  task automatic drive(input logic v, input logic r);
    @(posedge clk);
    #1;
    din_valid = v;
    rst       = r;
    @(negedge clk);
  endtask

  initial begin
    int n_bf, n_nr, n_fd, n_sh, n_dv;

    // ---- reset state ----
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    check("reset din_ready", 32'(a_ready), 32'd1);
    check("reset busy",      32'(a_busy),  32'd0);
    check("reset tw_idx",    32'(a_tw),    32'd0);
    check("reset dout_valid", 32'(a_dv),   32'd0);
    check("reset frame_done", 32'(a_fd),   32'd0);
    $display("reset: ready=%0d busy=%0d tw=%0d", a_ready, a_busy, a_tw);

    // ---- back-to-back frames, din_valid held high through DRAIN ----
    drive(1'b0, 1'b1);
    n_bf = 0; n_nr = 0; n_fd = 0; n_sh = 0;
    for (int c = 1; c <= 97; c++) begin
      drive(1'b1, 1'b0);
      if (a_bfly) n_bf++;
      if (!a_ready) n_nr++;
      if (a_fd) n_fd++;
      if (c <= 48 && a_shift) n_sh++;
      if (c >= 17 && c <= 32) check("frame1 tw_idx", 32'(a_tw), 32'(c - 17));
      if (c >= 65 && c <= 80) check("frame2 tw_idx", 32'(a_tw), 32'(c - 65));
      if (c == 49) begin
        check("frame_done cycle 49", 32'(a_fd), 32'd1);
        check("accept in frame_done cycle", 32'(a_ready & a_shift), 32'd1);
`ifdef FFT_CTRL_STALL_CNT_EN
        check("stall_cnt after frame", 32'(a_stall), 32'd16);
`endif
      end
      if (c == 97) check("frame_done cycle 97", 32'(a_fd), 32'd1);
      if (c == 7) check("d2 frame_done cycle 7", 32'(b_fd), 32'd1);
      $display("b2b cyc %0d: ready=%0d shift=%0d bfly=%0d tw=%0d dv=%0d fd=%0d",
               c, a_ready, a_shift, a_bfly, a_tw, a_dv, a_fd);
    end
    check("shifts in 48 cycles", 32'(n_sh), 32'd48);
    check("bfly_en count 2 frames", 32'(n_bf), 32'd32);
    check("din_ready low count", 32'(n_nr), 32'd32);
    check("frame_done count", 32'(n_fd), 32'd2);

    // ---- din_valid toggled during FILL and BFLY ----
    drive(1'b0, 1'b1);
    n_dv = 0;
    for (int c = 1; c <= 80; c++) begin
      drive((c > 64) ? 1'b1 : logic'(c % 2), 1'b0);
      if (a_dv) n_dv++;
      if (c == 80) check("toggle frame_done cycle 80", 32'(a_fd), 32'd1);
      $display("toggle cyc %0d: valid=%0d ready=%0d tw=%0d dv=%0d fd=%0d",
               c, din_valid, a_ready, a_tw, a_dv, a_fd);
    end
    check("toggle dout_valid count", 32'(n_dv), 32'd32);

    // ---- reset pulsed at BFLY cnt=7 ----
    drive(1'b0, 1'b1);
    for (int c = 1; c <= 23; c++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    check("pre-abort tw_idx", 32'(a_tw), 32'd7);
    check("pre-abort bfly_en", 32'(a_bfly), 32'd1);
    drive(1'b0, 1'b0);
    check("abort busy", 32'(a_busy), 32'd0);
    check("abort din_ready", 32'(a_ready), 32'd1);
    check("abort tw_idx", 32'(a_tw), 32'd0);
    n_fd = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 1'b0);
      if (a_fd) n_fd++;
    end
    check("abort no frame_done", 32'(n_fd), 32'd0);
    $display("abort: busy=%0d ready=%0d frame_done pulses=%0d", a_busy, a_ready, n_fd);

    // ---- randomized traffic with occasional resets ----
    for (int c = 0; c < 4000; c++) begin
      int pct;
      pct = (c / 500) % 4 == 0 ? 95 : ((c / 500) % 4 == 1 ? 50 : ((c / 500) % 4 == 2 ? 15 : 80));
      drive(logic'($urandom_range(0, 99) < pct), logic'($urandom_range(0, 599) == 0));
      $display("rand cyc %0d: rst=%0d valid=%0d ready=%0d shift=%0d bfly=%0d tw=%0d dv=%0d fd=%0d",
               c, rst, din_valid, a_ready, a_shift, a_bfly, a_tw, a_dv, a_fd);
    end

    drive(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
